axi_sram_slave: RTL and testbench

- AXI3-subset slave memory that sits directly downstream of the core's external AXI master ports (after the memory arbiter).
- Services single-ID-at-a-time incrementing bursts, one read channel and one write channel, operating concurrently.
- Backed by a word-addressed synchronous RAM array.
- Used as the simulation/FPGA main memory behind the core.

---
 rtl/axi_slave_pkg.sv | 19 +
 rtl/sram_2p.sv | 34 +++
 rtl/axi_sram_slave.sv | 199 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_pkg.sv
// Shared types and widths for the AXI3-subset SRAM slave.
package axi_slave_pkg;

    localparam int AXI_ID_WIDTH  = 4;
    localparam int AXI_LEN_WIDTH = 4;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BURST
    } rd_state_t;

endpackage

// File: rtl/sram_2p.sv
// Word-addressed RAM: one write port, one registered read port with enable.
// A same-cycle write to the word being read returns the old contents.
module sram_2p #(
    parameter int DEPTH_LOG2 = 14,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value while re is low, giving a stable beat under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3-subset incrementing-burst slave backed by sram_2p; independent read/write FSMs.
// Optional `AXI_SLAVE_STALL_EN: LFSR-driven ready gating and RVALID start delay.
module axi_sram_slave
    import axi_slave_pkg::*;
#(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 14,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [AXI_ID_WIDTH-1:0]  AWID,
    input  logic [AXI_LEN_WIDTH-1:0] AWLEN,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic                     WLAST,
    input  logic [AXI_ID_WIDTH-1:0]  WID,
    input  logic [DATA_WIDTH-1:0]    WDATA,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [AXI_ID_WIDTH-1:0]  BID,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]  ARID,
    input  logic [AXI_LEN_WIDTH-1:0] ARLEN,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic                     RLAST,
    output logic [AXI_ID_WIDTH-1:0]  RID,
    output logic [DATA_WIDTH-1:0]    RDATA,
    output logic                     protocol_err
);

    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [AXI_ID_WIDTH-1:0]  wr_id, rd_id;
    logic [DEPTH_LOG2-1:0]    wr_addr, rd_addr, ram_raddr;
    logic [AXI_LEN_WIDTH-1:0] wr_cnt, rd_cnt;
    logic [WAIT_W-1:0]        wait_cnt;
    logic                     aw_hs, w_hs, ar_hs, r_hs, ram_re;
    logic                     aw_block, w_block, ar_block, rv_hold;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^{AWADDR[ADDR_WIDTH-1:DEPTH_LOG2], ARADDR[ADDR_WIDTH-1:DEPTH_LOG2]};

`ifdef AXI_SLAVE_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign rv_hold  = lfsr[0];
    assign aw_block = lfsr[1];
    assign w_block  = lfsr[2];
    assign ar_block = lfsr[3];
`else
    assign rv_hold  = 1'b0;
    assign aw_block = 1'b0;
    assign w_block  = 1'b0;
    assign ar_block = 1'b0;
`endif

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;
    assign ar_hs = ARVALID & ARREADY;
    assign r_hs  = RVALID & RREADY;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                AWREADY = ~aw_block;
                if (AWVALID && !aw_block) wr_next = W_DATA;
            end
            W_DATA: begin
                WREADY = ~w_block;
                if (WVALID && !w_block && wr_cnt == '0) wr_next = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // The next beat's word is fetched on the accepting edge so beats stream without bubbles.
    always_comb begin
        rd_next   = rd_state;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        ram_re    = 1'b0;
        ram_raddr = rd_addr;
        unique case (rd_state)
            R_IDLE: begin
                ARREADY = ~ar_block;
                if (ARVALID && !ar_block) rd_next = R_WAIT;
            end
            R_WAIT: begin
                ram_re = 1'b1;
                if (wait_cnt == '0 && !rv_hold) rd_next = R_BURST;
            end
            R_BURST: begin
                RVALID = 1'b1;
                if (RREADY) begin
                    if (rd_cnt == '0) begin
                        rd_next = R_IDLE;
                    end else begin
                        ram_re    = 1'b1;
                        ram_raddr = rd_addr + DEPTH_LOG2'(1);
                    end
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    assign RLAST = (rd_state == R_BURST) && (rd_cnt == '0);
    assign RID   = rd_id;
    assign BID   = wr_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_id        <= '0;
            wr_addr      <= '0;
            wr_cnt       <= '0;
            rd_id        <= '0;
            rd_addr      <= '0;
            rd_cnt       <= '0;
            wait_cnt     <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (aw_hs) begin
                wr_id   <= AWID;
                wr_addr <= AWADDR[DEPTH_LOG2-1:0];
                wr_cnt  <= AWLEN;
            end
            if (w_hs) begin
                wr_addr <= wr_addr + DEPTH_LOG2'(1);
                wr_cnt  <= wr_cnt - AXI_LEN_WIDTH'(1);
                if ((WLAST != (wr_cnt == '0)) || (WID != wr_id)) protocol_err <= 1'b1;
            end
            if (ar_hs) begin
                rd_id    <= ARID;
                rd_addr  <= ARADDR[DEPTH_LOG2-1:0];
                rd_cnt   <= ARLEN;
                wait_cnt <= WAIT_W'(READ_LATENCY - 1);
            end
            if (rd_state == R_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (r_hs && rd_cnt != '0) begin
                rd_addr <= rd_addr + DEPTH_LOG2'(1);
                rd_cnt  <= rd_cnt - AXI_LEN_WIDTH'(1);
            end
        end
    end

    sram_2p #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (w_hs),
        .waddr(wr_addr),
        .wdata(WDATA),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(RDATA)
    );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave against a word-array memory model.
module tb_axi_sram_slave;

    localparam int RL    = 2;
    localparam int DL    = 14;
    localparam int DEPTH = 2 ** DL;

    logic        clk, rst;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [3:0]  AWID, AWLEN, WID, BID, ARID, ARLEN, RID;
    logic [25:0] AWADDR, ARADDR;
    logic [31:0] WDATA, RDATA;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST, protocol_err;

    axi_sram_slave #(
        .ADDR_WIDTH  (26),
        .DATA_WIDTH  (32),
        .DEPTH_LOG2  (DL),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    // Reference memory: plain word array indexed modulo the RAM depth.
    logic [31:0] model_mem [DEPTH];

    logic [31:0] wdat [16];
    bit          w_ok, w_early_b;
    logic        w_wready_after;
    int          w_beats;
    logic [3:0]  got_bid;

    logic [31:0] got_data [16];
    logic        got_last [16];
    logic [3:0]  got_id   [16];
    bit          r_ok, r_gap, r_stable;
    int          r_lat;

    function automatic int widx(input logic [25:0] addr, input int b);
        return (int'(addr) + b) % DEPTH;
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [25:0] addr,
                             input logic [3:0] len, input int wlast_pos);
        bit hs;
        w_ok = 1; w_beats = 0; w_early_b = 0; got_bid = 'x;
        AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        hs = 0;
        for (int i = 0; i < 100 && !hs; i++) begin hs = AWREADY; @(posedge clk); #1; end
        AWVALID = 1'b0;
        if (!hs) w_ok = 0;
        for (int b = 0; b <= int'(len) && w_ok; b++) begin
            WID = id; WDATA = wdat[b]; WVALID = 1'b1;
            WLAST = (wlast_pos < 0) ? (b == int'(len)) : (b == wlast_pos);
            hs = 0;
            for (int i = 0; i < 100 && !hs; i++) begin
                if (BVALID) w_early_b = 1;
                hs = WREADY; @(posedge clk); #1;
            end
            if (hs) begin
                w_beats++;
                model_mem[widx(addr, b)] = wdat[b];
            end else w_ok = 0;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        w_wready_after = WREADY;
        BREADY = 1'b1; hs = 0;
        for (int i = 0; i < 100 && !hs; i++) begin
            if (BVALID) got_bid = BID;
            hs = BVALID; @(posedge clk); #1;
        end
        BREADY = 1'b0;
        if (!hs) w_ok = 0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len,
                            input int stall_beat, input int stall_cycles);
        bit hs, started;
        int ar_cyc, beat, stall_left;
        logic [31:0] snap_d;
        logic snap_l;
        r_ok = 1; r_lat = -1; r_gap = 0; r_stable = 1;
        beat = 0; stall_left = stall_cycles; started = 0; snap_d = '0; snap_l = 1'b0;
        ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1; hs = 0;
        for (int i = 0; i < 100 && !hs; i++) begin hs = ARREADY; @(posedge clk); #1; end
        ARVALID = 1'b0; ar_cyc = cyc;
        if (!hs) r_ok = 0;
        for (int i = 0; i < 300 && r_ok && beat <= int'(len); i++) begin
            if (RVALID) begin
                if (!started) r_lat = cyc - ar_cyc;
                started = 1;
                if (beat == stall_beat && stall_left > 0) begin
                    if (stall_left == stall_cycles) begin snap_d = RDATA; snap_l = RLAST; end
                    else if (RDATA !== snap_d || RLAST !== snap_l) r_stable = 0;
                    RREADY = 1'b0; stall_left--;
                end else begin
                    if (beat == stall_beat && stall_cycles > 0 && (RDATA !== snap_d || RLAST !== snap_l))
                        r_stable = 0;
                    RREADY = 1'b1;
                    got_data[beat] = RDATA; got_last[beat] = RLAST; got_id[beat] = RID;
                    beat++;
                end
            end else if (started) r_gap = 1;
            @(posedge clk); #1;
        end
        RREADY = 1'b0;
        if (beat <= int'(len)) r_ok = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0; WVALID = 0; WLAST = 0; WID = 0; WDATA = 0;
        BREADY = 0; ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0; RREADY = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (AWREADY !== 1'b1) $display("FAIL reset_awready got=%b exp=1", AWREADY); else passed++;
        checks++; if (ARREADY !== 1'b1) $display("FAIL reset_arready got=%b exp=1", ARREADY); else passed++;
        checks++; if (WREADY !== 1'b0) $display("FAIL reset_wready got=%b exp=0", WREADY); else passed++;
        checks++; if (BVALID !== 1'b0) $display("FAIL reset_bvalid got=%b exp=0", BVALID); else passed++;
        checks++; if (RVALID !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", RVALID); else passed++;
        checks++; if (RLAST !== 1'b0) $display("FAIL reset_rlast got=%b exp=0", RLAST); else passed++;
        checks++; if (BID !== 4'h0 || RID !== 4'h0) $display("FAIL reset_ids got=%h/%h exp=0/0", BID, RID); else passed++;
        checks++; if (RDATA !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", RDATA); else passed++;
        checks++; if (protocol_err !== 1'b0) $display("FAIL reset_perr got=%b exp=0", protocol_err); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        wdat[0] = 32'hDEADBEEF;
        axi_write(4'h5, 26'h10, 4'd0, -1);
        checks++; if (w_ok !== 1'b1) $display("FAIL single_write_done got=%b exp=1", w_ok); else passed++;
        checks++; if (got_bid !== 4'h5) $display("FAIL single_bid got=%h exp=5", got_bid); else passed++;
        axi_read(4'h9, 26'h10, 4'd0, -1, 0);
        checks++; if (r_ok !== 1'b1) $display("FAIL single_read_done got=%b exp=1", r_ok); else passed++;
        checks++; if (got_data[0] !== 32'hDEADBEEF) $display("FAIL single_rdata got=%h exp=deadbeef", got_data[0]); else passed++;
        checks++; if (got_last[0] !== 1'b1) $display("FAIL single_rlast got=%b exp=1", got_last[0]); else passed++;
        checks++; if (got_id[0] !== 4'h9) $display("FAIL single_rid got=%h exp=9", got_id[0]); else passed++;
        checks++; if (r_lat != RL) $display("FAIL single_latency got=%0d exp=%0d", r_lat, RL); else passed++;
    endtask

    task automatic test_burst16;
        for (int i = 0; i < 16; i++) wdat[i] = 32'(i);
        axi_write(4'hA, 26'h100, 4'd15, -1);
        checks++; if (w_ok !== 1'b1 || w_beats != 16) $display("FAIL burst16_write got=%b/%0d exp=1/16", w_ok, w_beats); else passed++;
        checks++; if (got_bid !== 4'hA) $display("FAIL burst16_bid got=%h exp=a", got_bid); else passed++;
        axi_read(4'h3, 26'h100, 4'd15, -1, 0);
        checks++; if (r_ok !== 1'b1 || r_gap !== 1'b0) $display("FAIL burst16_stream got=ok%b gap%b exp=ok1 gap0", r_ok, r_gap); else passed++;
        checks++; if (r_lat != RL) $display("FAIL burst16_latency got=%0d exp=%0d", r_lat, RL); else passed++;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_data[i] !== 32'(i) || got_last[i] !== (i == 15) || got_id[i] !== 4'h3)
                $display("FAIL burst16_beat%0d got=%h/%b/%h exp=%h/%b/3", i, got_data[i], got_last[i], got_id[i], i, i == 15);
            else passed++;
        end
    endtask

    task automatic test_rready_stall;
        axi_read(4'h7, 26'h100, 4'd15, 1, 5);
        checks++; if (r_ok !== 1'b1) $display("FAIL stall_done got=%b exp=1", r_ok); else passed++;
        checks++; if (r_stable !== 1'b1) $display("FAIL stall_stable got=%b exp=1", r_stable); else passed++;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_data[i] !== model_mem[widx(26'h100, i)] || got_last[i] !== (i == 15))
                $display("FAIL stall_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], model_mem[widx(26'h100, i)], i == 15);
            else passed++;
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 4; i++) wdat[i] = $urandom;
        axi_write(4'h2, 26'(DEPTH - 2), 4'd3, -1);
        checks++; if (w_ok !== 1'b1) $display("FAIL wrap_write got=%b exp=1", w_ok); else passed++;
        axi_read(4'h4, 26'(DEPTH - 2), 4'd3, -1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== wdat[i]) $display("FAIL wrap_beat%0d got=%h exp=%h", i, got_data[i], wdat[i]); else passed++;
        end
        axi_read(4'h4, 26'h0, 4'd1, -1, 0);
        checks++; if (got_data[0] !== wdat[2]) $display("FAIL wrap_word0 got=%h exp=%h", got_data[0], wdat[2]); else passed++;
        checks++; if (got_data[1] !== wdat[3]) $display("FAIL wrap_word1 got=%h exp=%h", got_data[1], wdat[3]); else passed++;
    endtask

    task automatic test_wlast_err;
        checks++; if (protocol_err !== 1'b0) $display("FAIL perr_clean got=%b exp=0", protocol_err); else passed++;
        for (int i = 0; i < 4; i++) wdat[i] = 32'hA5A50000 + 32'(i);
        axi_write(4'h6, 26'h300, 4'd3, 1);
        checks++; if (protocol_err !== 1'b1) $display("FAIL perr_set got=%b exp=1", protocol_err); else passed++;
        checks++; if (w_ok !== 1'b1 || w_beats != 4) $display("FAIL perr_beats got=%b/%0d exp=1/4", w_ok, w_beats); else passed++;
        checks++; if (w_early_b !== 1'b0) $display("FAIL perr_early_bvalid got=%b exp=0", w_early_b); else passed++;
        checks++; if (w_wready_after !== 1'b0) $display("FAIL perr_wready_after got=%b exp=0", w_wready_after); else passed++;
        checks++; if (got_bid !== 4'h6) $display("FAIL perr_bid got=%h exp=6", got_bid); else passed++;
        wdat[0] = 32'h12345678;
        axi_write(4'h1, 26'h310, 4'd0, -1);
        checks++; if (protocol_err !== 1'b1) $display("FAIL perr_sticky got=%b exp=1", protocol_err); else passed++;
        axi_read(4'h8, 26'h300, 4'd3, -1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== 32'hA5A50000 + 32'(i)) $display("FAIL perr_data%0d got=%h exp=%h", i, got_data[i], 32'hA5A50000 + 32'(i)); else passed++;
        end
    endtask

    task automatic test_random;
        logic [3:0]  id, len;
        logic [25:0] waddr, raddr;
        int sb;
        for (int t = 0; t < 8; t++) begin
            id = 4'($urandom); len = 4'($urandom); waddr = 26'($urandom);
            for (int i = 0; i < 16; i++) wdat[i] = $urandom;
            axi_write(id, waddr, len, -1);
            checks++; if (w_ok !== 1'b1 || got_bid !== id) $display("FAIL rand%0d_write got=%b/%h exp=1/%h", t, w_ok, got_bid, id); else passed++;
            raddr = {12'($urandom), waddr[13:0]};
            sb = $urandom_range(0, int'(len));
            axi_read(~id, raddr, len, sb, $urandom_range(0, 3));
            checks++; if (r_ok !== 1'b1 || r_gap !== 1'b0 || r_stable !== 1'b1) $display("FAIL rand%0d_read got=%b%b%b exp=101", t, r_ok, r_gap, r_stable); else passed++;
            for (int i = 0; i <= int'(len); i++) begin
                checks++;
                if (got_data[i] !== model_mem[widx(raddr, i)] || got_last[i] !== (i == int'(len)) || got_id[i] !== ~id)
                    $display("FAIL rand%0d_beat%0d got=%h/%b/%h exp=%h/%b/%h", t, i, got_data[i], got_last[i], got_id[i],
                             model_mem[widx(raddr, i)], i == int'(len), ~id);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_read;
        bit hs, done;
        int beats;
        for (int i = 0; i < 8; i++) wdat[i] = 32'hC0DE0000 + 32'(i * 3);
        axi_write(4'h1, 26'h200, 4'd7, -1);
        ARID = 4'hB; ARADDR = 26'h200; ARLEN = 4'd7; ARVALID = 1'b1; hs = 0;
        for (int i = 0; i < 100 && !hs; i++) begin hs = ARREADY; @(posedge clk); #1; end
        ARVALID = 1'b0; RREADY = 1'b1;
        beats = 0; done = 0;
        for (int i = 0; i < 100 && hs && !done; i++) begin
            if (RVALID && beats == 2) begin
                rst = 1'b1; RREADY = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0; done = 1;
            end else begin
                if (RVALID) beats++;
                @(posedge clk); #1;
            end
        end
        RREADY = 1'b0;
        checks++; if (done !== 1'b1) $display("FAIL midrst_reached got=%b exp=1", done); else passed++;
        checks++; if (RVALID !== 1'b0) $display("FAIL midrst_rvalid got=%b exp=0", RVALID); else passed++;
        checks++; if (ARREADY !== 1'b1) $display("FAIL midrst_arready got=%b exp=1", ARREADY); else passed++;
        checks++; if (RDATA !== 32'h0 || protocol_err !== 1'b0) $display("FAIL midrst_regs got=%h/%b exp=0/0", RDATA, protocol_err); else passed++;
        axi_read(4'hC, 26'h204, 4'd3, -1, 0);
        checks++; if (r_ok !== 1'b1 || r_lat != RL) $display("FAIL midrst_newread got=%b/%0d exp=1/%0d", r_ok, r_lat, RL); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== 32'hC0DE0000 + 32'((i + 4) * 3) || got_id[i] !== 4'hC || got_last[i] !== (i == 3))
                $display("FAIL midrst_beat%0d got=%h/%h/%b exp=%h/c/%b", i, got_data[i], got_id[i], got_last[i],
                         32'hC0DE0000 + 32'((i + 4) * 3), i == 3);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst16();
        test_rready_stall();
        test_wrap();
        test_wlast_err();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
